// File: rtl/reg_leaf_responder.sv
// reg_leaf_responder: leaf register responder (counters, sw regs, hw regs); `COUNTER_CLEAR_ON_READ_EN makes counter reads clear-on-read
module reg_leaf_responder #(
  parameter int REG_ADDR_BITS = 8,
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_SW_REGS = 4,
  parameter int NUM_HW_REGS = 2,
  parameter int COUNTER_INC_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic reg_req,
  input  logic reg_rd_wr_L,
  input  logic [REG_ADDR_BITS-1:0] reg_addr,
  input  logic [31:0] reg_wr_data,
  output logic reg_ack,
  output logic [31:0] reg_rd_data,
  input  logic [NUM_COUNTERS*COUNTER_INC_WIDTH-1:0] counter_updates,
  output logic [NUM_SW_REGS*32-1:0] software_regs,
  input  logic [NUM_HW_REGS*32-1:0] hardware_regs
);
  localparam int AW = REG_ADDR_BITS;
  localparam logic [AW:0] CNT_END = (AW+1)'(NUM_COUNTERS);
  localparam logic [AW:0] SW_END = (AW+1)'(NUM_COUNTERS + NUM_SW_REGS);
  localparam logic [AW:0] HW_END = (AW+1)'(NUM_COUNTERS + NUM_SW_REGS + NUM_HW_REGS);
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, DECODE, ACK, WAIT_LOW} state_t;

  state_t state, state_nxt;
  logic fire;
  logic rd_q, is_cnt, is_sw, is_hw;
  logic [AW-1:0] idx;
  logic [AW:0] addr_x;
  logic dec_cnt, dec_sw, dec_hw;
  logic [AW-1:0] dec_idx;
  logic [31:0] cnt [NUM_COUNTERS];
  logic [31:0] inc [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] clr;
  logic [31:0] sw [NUM_SW_REGS];
  logic [31:0] cnt_rd, sw_rd, hw_rd, rd_val;

  // Decode the live address into a target class and index within that class
  always_comb begin
    addr_x = {1'b0, reg_addr};
    dec_cnt = addr_x < CNT_END;
    dec_sw = !dec_cnt && addr_x < SW_END;
    dec_hw = !dec_cnt && !dec_sw && addr_x < HW_END;
    dec_idx = dec_cnt ? reg_addr : dec_sw ? reg_addr - CNT_END[AW-1:0] : reg_addr - SW_END[AW-1:0];
  end

  // Handshake sequencing; fire marks the cycle the access completes
  always_comb begin
    state_nxt = state;
    fire = 1'b0;
    case (state)
      IDLE: state_nxt = reg_req ? DECODE : IDLE;
      DECODE: begin
        fire = reg_req;
        state_nxt = reg_req ? ACK : IDLE;
      end
      ACK: state_nxt = WAIT_LOW;
      WAIT_LOW: state_nxt = reg_req ? WAIT_LOW : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read value of the latched target, counter increments and read-clears
  always_comb begin
    cnt_rd = '0;
    sw_rd = '0;
    hw_rd = '0;
    clr = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      inc[i] = 32'(counter_updates[i*COUNTER_INC_WIDTH +: COUNTER_INC_WIDTH]);
      cnt_rd = idx == AW'(i) ? cnt[i] : cnt_rd;
`ifdef COUNTER_CLEAR_ON_READ_EN
      clr[i] = fire && rd_q && is_cnt && idx == AW'(i);
`endif
    end
    for (int j = 0; j < NUM_SW_REGS; j++) sw_rd = idx == AW'(j) ? sw[j] : sw_rd;
    for (int k = 0; k < NUM_HW_REGS; k++) hw_rd = idx == AW'(k) ? hardware_regs[k*32 +: 32] : hw_rd;
    rd_val = !rd_q ? ((is_cnt || is_sw || is_hw) ? 32'h0 : BAD) :
             is_cnt ? cnt_rd : is_sw ? sw_rd : is_hw ? hw_rd : BAD;
  end

  // State register, request latch at acceptance, and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      reg_ack <= 1'b0;
      reg_rd_data <= '0;
      rd_q <= 1'b0;
      is_cnt <= 1'b0;
      is_sw <= 1'b0;
      is_hw <= 1'b0;
      idx <= '0;
    end else begin
      state <= state_nxt;
      reg_ack <= fire;
      if (fire) reg_rd_data <= rd_val;
      if (state == IDLE && reg_req) begin
        rd_q <= reg_rd_wr_L;
        is_cnt <= dec_cnt;
        is_sw <= dec_sw;
        is_hw <= dec_hw;
        idx <= dec_idx;
      end
    end
  end

  // Event counters accumulate every cycle and wrap; a clearing read restarts from this cycle's increment
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_COUNTERS; i++)
      cnt[i] <= reset ? '0 : clr[i] ? inc[i] : cnt[i] + inc[i];

  // Software registers take write data when their write completes
  always_ff @(posedge clk)
    for (int j = 0; j < NUM_SW_REGS; j++)
      sw[j] <= reset ? '0 : (fire && !rd_q && is_sw && idx == AW'(j)) ? reg_wr_data : sw[j];

  // Flatten software registers onto the output bus
  always_comb
    for (int j = 0; j < NUM_SW_REGS; j++) software_regs[j*32 +: 32] = sw[j];
endmodule

// File: tb/tb_reg_leaf_responder.sv
// tb_reg_leaf_responder: scoreboard bench with a behavioural register-map model
module tb_reg_leaf_responder;
  // wide increments let the 32-bit wrap be reached in a few cycles
  localparam int AB = 8, NC = 4, NSW = 4, NHW = 2, CW = 31;
  localparam int NREG = NC + NSW + NHW;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic clk = 0, reset = 1, reg_req = 0, reg_rd_wr_L = 1, reg_ack;
  logic [AB-1:0] reg_addr = '0;
  logic [31:0] reg_wr_data = '0, reg_rd_data;
  logic [NC*CW-1:0] counter_updates = '0;
  logic [NSW*32-1:0] software_regs;
  logic [NHW*32-1:0] hardware_regs = '0;

  logic [31:0] m_cnt [NC] = '{default: '0};
  logic [31:0] m_sw [NSW] = '{default: '0};
  logic [31:0] exp_q [$];
  int cyc_q [$];
  int cyc = 0, n_chk = 0, n_fail = 0, pend_sw = -1, pend_clr = -1, c;
  logic [31:0] pend_data = '0, last_rd = '0, e;
  bit rand_upd = 0, done = 0;

  reg_leaf_responder #(
    .REG_ADDR_BITS(AB), .NUM_COUNTERS(NC), .NUM_SW_REGS(NSW),
    .NUM_HW_REGS(NHW), .COUNTER_INC_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_ack(reg_ack),
    .reg_rd_data(reg_rd_data), .counter_updates(counter_updates),
    .software_regs(software_regs), .hardware_regs(hardware_regs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] read_model(input int a);
    if (a < NC) return m_cnt[a];
    if (a < NC + NSW) return m_sw[a - NC];
    if (a < NREG) return hardware_regs[(a - NC - NSW)*32 +: 32];
    return BAD;
  endfunction

  function automatic logic [NSW*32-1:0] sw_flat();
    logic [NSW*32-1:0] f;
    for (int j = 0; j < NSW; j++) f[j*32 +: 32] = m_sw[j];
    return f;
  endfunction

  // one clock: model absorbs the edge, then new increments are driven on the falling edge
  task automatic tick();
    logic [31:0] inc;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = '0;
      for (int j = 0; j < NSW; j++) m_sw[j] = '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        inc = 32'(counter_updates[i*CW +: CW]);
        m_cnt[i] = (i == pend_clr) ? inc : m_cnt[i] + inc;
      end
      if (pend_sw >= 0) m_sw[pend_sw] = pend_data;
    end
    pend_sw = -1;
    pend_clr = -1;
    @(negedge clk);
    if (rand_upd)
      for (int i = 0; i < NC; i++)
        counter_updates[i*CW +: CW] = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 7));
  endtask

  task automatic xact(input bit rd, input int a, input logic [31:0] wd, input int hold);
    reg_req = 1;
    reg_rd_wr_L = rd;
    reg_addr = AB'(a);
    reg_wr_data = wd;
    tick();
    exp_q.push_back(rd ? read_model(a) : (a >= NREG ? BAD : 32'h0));
    cyc_q.push_back(cyc + 1);
    if (!rd && a >= NC && a < NC + NSW) begin
      pend_sw = a - NC;
      pend_data = wd;
    end
`ifdef COUNTER_CLEAR_ON_READ_EN
    if (rd && a < NC) pend_clr = a;
`endif
    tick();
    tick();
    repeat (hold) tick();
    reg_req = 0;
    reg_rd_wr_L = 1'($urandom);
    reg_addr = AB'($urandom);
    repeat (1 + $urandom_range(0, 2)) tick();
  endtask

  task automatic abort_req(input int a);
    reg_req = 1;
    reg_rd_wr_L = 0;
    reg_addr = AB'(a);
    reg_wr_data = $urandom;
    tick();
    reg_req = 0;
    repeat (2) tick();
  endtask

  initial begin
    int a;
    repeat (3) tick();
    #1 reset = 0;
    tick();
    xact(1, 4, 0, 0);
    xact(0, 5, 32'hA5A5_0001, 0);
    xact(1, 5, 0, 1);
    counter_updates[1*CW +: CW] = 3;
    repeat (10) tick();
    counter_updates = '0;
    xact(1, 1, 0, 0);
    counter_updates[1*CW +: CW] = 3;
    xact(1, 1, 0, 0);
    xact(1, 1, 0, 2);
    counter_updates = '0;
    counter_updates[0 +: CW] = 31'h7FFF_FFFF;
    repeat (2) tick();
    counter_updates[0 +: CW] = 5;
    tick();
    counter_updates = '0;
    xact(1, 0, 0, 0);
    xact(1, 8'h80, 0, 0);
    xact(0, 8'h80, 32'h1, 0);
    xact(0, 2, 32'hFFFF_FFFF, 0);
    hardware_regs = {32'h5678_9ABC, 32'h0000_1234};
    xact(0, 8, 32'hFFFF_0000, 0);
    xact(1, 8, 0, 0);
    xact(1, 9, 0, 0);
    abort_req(6);
    xact(1, 6, 0, 0);
    xact(0, 7, 32'h1111_2222, 0);
    reg_req = 1;
    reg_rd_wr_L = 0;
    reg_addr = 7;
    reg_wr_data = 32'hCAFE_F00D;
    tick();
    #1 reset = 1;
    tick();
    #1 reset = 0;
    reg_req = 0;
    tick();
    xact(1, 7, 0, 0);
    xact(0, 7, 32'h0BAD_F00D, 0);
    xact(1, 7, 0, 0);
    rand_upd = 1;
    repeat (250) begin
      for (int k = 0; k < NHW; k++) hardware_regs[k*32 +: 32] = $urandom;
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, NREG + 1);
      xact(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) abort_req($urandom_range(0, NREG - 1));
    end
    rand_upd = 0;
    repeat (4) tick();
    done = 1;
  end

  // monitor: scoreboard pops on every ack, plus reset/hold/sw-output checks each cycle
  always @(negedge clk) begin
    n_chk++;
    if (software_regs !== sw_flat()) begin
      n_fail++;
      $display("FAIL software_regs got=%h required=%h", software_regs, sw_flat());
    end
    if (reset) begin
      n_chk++;
      if (reg_ack !== 1'b0 || reg_rd_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state got ack=%b rd_data=%h required ack=0 rd_data=0", reg_ack, reg_rd_data);
      end
      last_rd = '0;
    end else if (reg_ack) begin
      n_chk++;
      if (!reg_req) begin
        n_fail++;
        $display("FAIL ack_without_req got ack=1 req=0 required req=1");
      end
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack got ack=1 at cycle %0d required no ack", cyc);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        n_chk += 2;
        if (reg_rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data got=%h required=%h", reg_rd_data, e);
        end
        if (cyc != c) begin
          n_fail++;
          $display("FAIL ack_latency got cycle=%0d required cycle=%0d", cyc, c);
        end
        last_rd = e;
      end
    end else begin
      n_chk++;
      if (reg_rd_data !== last_rd) begin
        n_fail++;
        $display("FAIL rd_data_hold got=%h required=%h", reg_rd_data, last_rd);
      end
    end
    if (done) begin
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_ack got %0d outstanding required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "timeout");
  end
endmodule
